// File: rtl/d5m_tx_pkg.sv
// Shared types for the D5M camera transmitter: FSM state encoding, pattern
// select codes and a small sizing helper.
package d5m_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FRONT  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_BACK   = 3'd4,
    ST_VBLANK = 3'd5
  } d5m_tx_state_t;

  localparam logic [1:0] PAT_RAMP   = 2'd0;
  localparam logic [1:0] PAT_BAYER  = 2'd1;
  localparam logic [1:0] PAT_LINEAR = 2'd2;
  localparam logic [1:0] PAT_CHECK  = 2'd3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/d5m_camera_tx_if.sv
// D5M pixel bus: frame valid, line valid and pixel data, driven by the
// transmitter (master) and consumed by a d5m receiver (slave).
interface d5m_camera_tx_if #(
  parameter int dataWidth = 12
) ();
  logic                 ifval;
  logic                 ilval;
  logic [dataWidth-1:0] idata;

  modport master (output ifval, output ilval, output idata);
  modport slave  (input  ifval, input  ilval, input  idata);
endinterface

// File: rtl/d5m_pattern_gen.sv
// Registered test-pattern pixel generator; its output register sits in the
// same pipeline stage as the line-valid register in the top level.
module d5m_pattern_gen
  import d5m_tx_pkg::*;
#(
  parameter int img_width = 8,
  parameter int dataWidth = 12,
  parameter int XW        = 3,
  parameter int YW        = 2
) (
  input  logic                 pixclk,
  input  logic                 aresetn,
  input  logic                 i_active,
  input  logic [1:0]           i_pattern,
  input  logic [XW-1:0]        i_x,
  input  logic [YW-1:0]        i_y,
  output logic [dataWidth-1:0] o_data
);

  localparam logic [dataWidth-1:0] ALL_ONES = '1;
  localparam logic [dataWidth-1:0] GREEN    = dataWidth'(1) << (dataWidth - 1);
  localparam logic [dataWidth-1:0] WIDTH_D  = dataWidth'(img_width);

  logic [dataWidth-1:0] w_pixel;
  logic [dataWidth-1:0] w_linear;
  logic [dataWidth-1:0] r_data;

  assign w_linear = dataWidth'(i_y) * WIDTH_D + dataWidth'(i_x);

  // GRBG: even rows are G,R; odd rows are B,G
  always_comb begin
    w_pixel = '0;
    case (i_pattern)
      PAT_RAMP:   w_pixel = dataWidth'(i_x);
      PAT_BAYER: begin
        if (!i_y[0]) w_pixel = i_x[0] ? ALL_ONES : GREEN;
        else         w_pixel = i_x[0] ? GREEN : '0;
      end
      PAT_LINEAR: w_pixel = w_linear;
      PAT_CHECK:  w_pixel = (i_x[0] ^ i_y[0]) ? ALL_ONES : '0;
      default:    w_pixel = '0;
    endcase
  end

  always_ff @(posedge pixclk or negedge aresetn) begin
    if (!aresetn) r_data <= '0;
    else          r_data <= i_active ? w_pixel : '0;
  end

  assign o_data = r_data;

endmodule

// File: rtl/d5m_camera_tx.sv
// D5M camera sensor transmitter: frame/line timing FSM with porch and blanking
// counters, plus a registered pattern source on the pixel bus.
module d5m_camera_tx
  import d5m_tx_pkg::*;
#(
  parameter int img_width  = 8,
  parameter int img_height = 4,
  parameter int h_blank    = 3,
  parameter int f_porch    = 2,
  parameter int b_porch    = 2,
  parameter int v_blank    = 5,
  parameter int dataWidth  = 12
) (
  input  logic                   pixclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [1:0]             pattern,
  d5m_camera_tx_if.master        bus,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);

  localparam int XW = $clog2(img_width);
  localparam int YW = $clog2(img_height);
  localparam int CW = $clog2(max4(h_blank, f_porch, b_porch, v_blank)) + 1;

  d5m_tx_state_t  r_state;
  logic [CW-1:0]  r_cnt;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [1:0]     r_pat;
  logic           r_ifval;
  logic           r_ilval;
  logic           r_frame_done;
  logic [15:0]    r_frame_count;
  logic           w_frame_end;
  logic [dataWidth-1:0] w_idata;

  assign w_frame_end = (r_state == ST_VBLANK) && (r_cnt == '0);

  // enable and pattern are only looked at when a new frame could start
  always_ff @(posedge pixclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_pat   <= PAT_RAMP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_FRONT;
            r_pat   <= pattern;
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
          end
        end
        ST_FRONT: begin
          if (r_cnt == CW'(f_porch - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_ACTIVE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        ST_ACTIVE: begin
          if (r_x == XW'(img_width - 1)) begin
            r_x     <= '0;
            r_state <= (r_y == YW'(img_height - 1)) ? ST_BACK : ST_HBLANK;
          end else r_x <= r_x + 1'b1;
        end
        ST_HBLANK: begin
          if (r_cnt == CW'(h_blank - 1)) begin
            r_cnt   <= '0;
            r_y     <= r_y + 1'b1;
            r_state <= ST_ACTIVE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        ST_BACK: begin
          if (r_cnt == CW'(b_porch - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_VBLANK;
          end else r_cnt <= r_cnt + 1'b1;
        end
        ST_VBLANK: begin
          if (r_cnt == CW'(v_blank - 1)) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            if (enable) begin
              r_state <= ST_FRONT;
              r_pat   <= pattern;
            end else r_state <= ST_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: one register behind the state, aligned with the pixel register
  always_ff @(posedge pixclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ifval       <= 1'b0;
      r_ilval       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_ifval      <= (r_state == ST_FRONT) || (r_state == ST_ACTIVE) ||
                      (r_state == ST_HBLANK) || (r_state == ST_BACK);
      r_ilval      <= (r_state == ST_ACTIVE);
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  d5m_pattern_gen #(
    .img_width (img_width),
    .dataWidth (dataWidth),
    .XW        (XW),
    .YW        (YW)
  ) u_pattern_gen (
    .pixclk    (pixclk),
    .aresetn   (aresetn),
    .i_active  (r_state == ST_ACTIVE),
    .i_pattern (r_pat),
    .i_x       (r_x),
    .i_y       (r_y),
    .o_data    (w_idata)
  );

  assign bus.ifval   = r_ifval;
  assign bus.ilval   = r_ilval;
  assign bus.idata   = w_idata;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_d5m_camera_tx.sv
// Directed self-checking bench for d5m_camera_tx with default parameters.
module tb_d5m_camera_tx;

  logic        pixclk;
  logic        aresetn;
  logic        enable;
  logic [1:0]  pattern;
  logic        frame_done;
  logic [15:0] frame_count;
  int          checks;
  int          failures;

  d5m_camera_tx_if #(.dataWidth(12)) bus ();

  d5m_camera_tx dut (
    .pixclk      (pixclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .pattern     (pattern),
    .bus         (bus),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  task automatic do_reset();
    enable  = 1'b0;
    pattern = 2'd0;
    aresetn = 1'b0;
    repeat (2) @(negedge pixclk);
    aresetn = 1'b1;
    @(negedge pixclk);
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    bad = 0;
    repeat (20) begin
      @(negedge pixclk);
      if (bus.ifval !== 1'b0 || bus.ilval !== 1'b0 || bus.idata !== 12'h0 || frame_done !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL reset_idle_outputs nonzero_cycles=%0d expected=0", bad);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_frame_count got=%0d expected=0", frame_count);
    end
  endtask

  task automatic test_single_frame();
    int ifHigh, bursts, badLen, badData, badGap, dones, len, gap, lateIf;
    logic prevL;
    do_reset();
    pattern = 2'd0;
    enable  = 1'b1;
    @(negedge pixclk);
    enable = 1'b0;
    ifHigh = 0; bursts = 0; badLen = 0; badData = 0; badGap = 0; dones = 0;
    len = 0; gap = 0; prevL = 1'b0; lateIf = 0;
    for (int i = 0; i < 90; i++) begin
      if (bus.ifval) ifHigh++;
      if (i >= 60 && bus.ifval) lateIf++;
      if (frame_done) dones++;
      if (bus.ilval && !prevL) begin
        if (bursts > 0 && gap != 3) badGap++;
        len = 0;
      end
      if (bus.ilval) begin
        if (bus.idata !== 12'(len)) badData++;
        len++;
      end else begin
        if (bus.idata !== 12'h0) badData++;
        if (prevL) begin
          bursts++;
          if (len != 8) badLen++;
          gap = 0;
        end
        gap++;
      end
      prevL = bus.ilval;
      @(negedge pixclk);
    end
    checks++;
    if (ifHigh !== 45) begin failures++; $display("[TB] FAIL single_ifval_high got=%0d expected=45", ifHigh); end
    checks++;
    if (bursts !== 4) begin failures++; $display("[TB] FAIL single_bursts got=%0d expected=4", bursts); end
    checks++;
    if (badLen !== 0) begin failures++; $display("[TB] FAIL single_burst_len bad=%0d expected=0", badLen); end
    checks++;
    if (badData !== 0) begin failures++; $display("[TB] FAIL single_ramp_data bad=%0d expected=0", badData); end
    checks++;
    if (badGap !== 0) begin failures++; $display("[TB] FAIL single_hblank_gap bad=%0d expected=0", badGap); end
    checks++;
    if (dones !== 1) begin failures++; $display("[TB] FAIL single_frame_done got=%0d expected=1", dones); end
    checks++;
    if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL single_frame_count got=%0d expected=1", frame_count); end
    checks++;
    if (lateIf !== 0) begin failures++; $display("[TB] FAIL single_back_to_idle ifval_cycles=%0d expected=0", lateIf); end
  endtask

  task automatic test_continuous();
    int rises, badPeriod, badData, pix, lastRise, pixTotal;
    logic prevF;
    do_reset();
    pattern = 2'd2;
    enable  = 1'b1;
    rises = 0; badPeriod = 0; badData = 0; pix = 0; lastRise = 0; pixTotal = 0; prevF = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pixclk);
      if (i == 120) enable = 1'b0;
      if (bus.ifval && !prevF) begin
        if (rises > 0 && (i - lastRise) != 50) badPeriod++;
        lastRise = i;
        rises++;
        pix = 0;
      end
      if (bus.ilval) begin
        if (bus.idata !== 12'(pix)) badData++;
        pix++;
        pixTotal++;
      end
      prevF = bus.ifval;
    end
    checks++;
    if (rises !== 3) begin failures++; $display("[TB] FAIL cont_frames got=%0d expected=3", rises); end
    checks++;
    if (badPeriod !== 0) begin failures++; $display("[TB] FAIL cont_period bad=%0d expected=0", badPeriod); end
    checks++;
    if (badData !== 0 || pixTotal !== 96) begin
      failures++;
      $display("[TB] FAIL cont_linear_data bad=%0d pixels=%0d expected bad=0 pixels=96", badData, pixTotal);
    end
    checks++;
    if (frame_count !== 16'd3) begin failures++; $display("[TB] FAIL cont_frame_count got=%0d expected=3", frame_count); end
  endtask

  task automatic test_bayer();
    logic [11:0] px [16];
    logic [11:0] exp;
    int n;
    do_reset();
    pattern = 2'd1;
    enable  = 1'b1;
    @(negedge pixclk);
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pixclk);
      if (bus.ilval && n < 16) begin
        px[n] = bus.idata;
        n++;
      end
    end
    checks++;
    if (n !== 16) begin failures++; $display("[TB] FAIL bayer_pixel_count got=%0d expected=16", n); end
    for (int k = 0; k < 16; k++) begin
      if (k < 8) exp = (k % 2 == 0) ? 12'h800 : 12'hFFF;
      else       exp = (k % 2 == 0) ? 12'h000 : 12'h800;
      if (k < n) begin
        checks++;
        if (px[k] !== exp) begin
          failures++;
          $display("[TB] FAIL bayer_pixel line=%0d x=%0d got=%h expected=%h", k / 8, k % 8, px[k], exp);
        end
      end
    end
  endtask

  task automatic test_pattern_switch();
    int n, badRamp, badCheck;
    logic [11:0] exp;
    do_reset();
    pattern = 2'd0;
    enable  = 1'b1;
    n = 0; badRamp = 0; badCheck = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge pixclk);
      if (i == 70) enable = 1'b0;
      if (bus.ilval) begin
        if (n == 2) pattern = 2'd3;
        if (n < 32) begin
          if (bus.idata !== 12'(n % 8)) badRamp++;
        end else if (n < 64) begin
          exp = (((n % 8) % 2) != (((n - 32) / 8) % 2)) ? 12'hFFF : 12'h000;
          if (bus.idata !== exp) badCheck++;
        end
        n++;
      end
    end
    checks++;
    if (n !== 64) begin failures++; $display("[TB] FAIL switch_pixel_count got=%0d expected=64", n); end
    checks++;
    if (badRamp !== 0) begin failures++; $display("[TB] FAIL switch_current_ramp bad=%0d expected=0", badRamp); end
    checks++;
    if (badCheck !== 0) begin failures++; $display("[TB] FAIL switch_next_checker bad=%0d expected=0", badCheck); end
  endtask

  task automatic test_reset_mid_frame();
    int rises, fi, li;
    logic prevL;
    logic [11:0] dataAtLi;
    do_reset();
    pattern = 2'd0;
    enable  = 1'b1;
    rises = 0; prevL = 1'b0;
    for (int i = 0; i < 60 && rises < 2; i++) begin
      @(negedge pixclk);
      if (bus.ilval && !prevL) rises++;
      prevL = bus.ilval;
    end
    checks++;
    if (rises !== 2) begin failures++; $display("[TB] FAIL midreset_reach_line2 got=%0d expected=2", rises); end
    @(negedge pixclk);
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (bus.ifval !== 1'b0 || bus.ilval !== 1'b0 || bus.idata !== 12'h0) begin
      failures++;
      $display("[TB] FAIL midreset_async_clear got ifval=%b ilval=%b idata=%h expected 0 0 000",
               bus.ifval, bus.ilval, bus.idata);
    end
    @(negedge pixclk);
    aresetn = 1'b1;
    fi = -1; li = -1; dataAtLi = 12'hABC;
    for (int i = 1; i <= 10; i++) begin
      @(negedge pixclk);
      if (bus.ifval && fi < 0) fi = i;
      if (bus.ilval && li < 0) begin li = i; dataAtLi = bus.idata; end
    end
    checks++;
    if (fi !== 2 || li !== 4) begin
      failures++;
      $display("[TB] FAIL midreset_restart_front got ifval_at=%0d ilval_at=%0d expected 2 4", fi, li);
    end
    checks++;
    if (dataAtLi !== 12'h000) begin failures++; $display("[TB] FAIL midreset_first_pixel got=%h expected=000", dataAtLi); end
    enable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    enable   = 1'b0;
    pattern  = 2'd0;
    aresetn  = 1'b0;
    test_reset();
    test_single_frame();
    test_continuous();
    test_bayer();
    test_pattern_switch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
